// File: rtl/spi_synced_tone_gen.sv
// SPI-word-synchronised multi-channel sine tone generator: each completed SPI word emits one sample.
// Define TONE_GAIN_EN to add a per-channel Q1.7 gain port and one extra output pipeline stage.
module spi_synced_tone_gen #(
  parameter int CHANNELS      = 2,
  parameter int SAMPLE_W      = 16,
  parameter int PHASE_W       = 16,
  parameter int ROM_ADDR_W    = 6,
  parameter int BITS_PER_WORD = 16,
  localparam int CHAN_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk_12mhz,
  input  logic                         reset,
  input  logic                         spi_sck,
  input  logic                         spi_cs,
  input  logic                         enable,
  input  logic [CHANNELS*PHASE_W-1:0]  phase_inc,
`ifdef TONE_GAIN_EN
  input  logic [CHANNELS*8-1:0]        gain,
`endif
  input  logic                         fifo_full,
  output logic signed [SAMPLE_W-1:0]   fifo_write_data,
  output logic                         fifo_write_en,
  output logic [CHAN_W-1:0]            fifo_write_chan,
  output logic [15:0]                  drop_count,
  output logic                         led
);

  localparam int  DEPTH = 1 << ROM_ADDR_W;
  localparam int  BC_W  = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam real PI    = 3.14159265358979323846;

  function automatic logic signed [SAMPLE_W-1:0] sine_entry(input int k);
    real amp;
    real x;
    amp = real'((1 << (SAMPLE_W - 1)) - 1);
    x   = amp * $sin(2.0 * PI * real'(k) / real'(DEPTH));
    return (x >= 0.0) ? SAMPLE_W'($rtoi(x + 0.5)) : SAMPLE_W'($rtoi(x - 0.5));
  endfunction

  logic [2:0]                 sck_sync;
  logic [2:0]                 cs_sync;
  logic                       sck_rise;
  logic                       cs_active;
  logic [BC_W-1:0]            bit_cnt;
  logic                       trig;
  logic                       consume;
  logic [CHAN_W-1:0]          chan_idx;
  logic [PHASE_W-1:0]         phase   [CHANNELS];
  logic [PHASE_W-1:0]         inc_arr [CHANNELS];
  logic signed [SAMPLE_W-1:0] sine_rom [DEPTH];

  logic [ROM_ADDR_W-1:0]      addr_p0;
  logic [CHAN_W-1:0]          chan_p0;
  logic                       take_p0;
  logic                       vld_p0;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic signed [SAMPLE_W-1:0] ENTRY = sine_entry(k);
    assign sine_rom[k] = ENTRY;
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_inc
    assign inc_arr[k] = phase_inc[k*PHASE_W +: PHASE_W];
  end

  // Whole-vector shifts: bit 0 samples the pin, bits 1 and 2 feed the edge detector.
  always_ff @(posedge clk_12mhz) begin
    sck_sync <= (sck_sync << 1) | {2'b00, spi_sck};
    cs_sync  <= (cs_sync << 1) | {2'b00, spi_cs};
  end

  assign sck_rise  = sck_sync[1] & ~sck_sync[2];
  assign cs_active = ~cs_sync[1];
  assign consume   = trig & enable;
  assign led       = phase[0][PHASE_W-1 -: ROM_ADDR_W] < ROM_ADDR_W'(DEPTH / 4);

  // Word framing, channel rotation, phase accumulation and drop accounting
  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      bit_cnt    <= '0;
      trig       <= 1'b0;
      chan_idx   <= '0;
      take_p0    <= 1'b0;
      vld_p0     <= 1'b0;
      drop_count <= '0;
      for (int i = 0; i < CHANNELS; i++) phase[i] <= '0;
    end else begin
      trig <= 1'b0;
      if (!cs_active) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        if (bit_cnt == BC_W'(BITS_PER_WORD - 1)) begin
          bit_cnt <= '0;
          trig    <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      take_p0 <= consume;
      vld_p0  <= consume & ~fifo_full;
      if (consume) begin
        phase[chan_idx] <= phase[chan_idx] + inc_arr[chan_idx];
        if (fifo_full && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
      end

      if (!cs_active)
        chan_idx <= '0;
      else if (consume)
        chan_idx <= (chan_idx == CHAN_W'(CHANNELS - 1)) ? '0 : chan_idx + 1'b1;
    end
  end

  // Stage p0: capture table address and channel of the consumed trigger
  always_ff @(posedge clk_12mhz) begin
    if (consume) begin
      addr_p0 <= phase[chan_idx][PHASE_W-1 -: ROM_ADDR_W];
      chan_p0 <= chan_idx;
    end
  end

`ifdef TONE_GAIN_EN
  function automatic logic signed [SAMPLE_W-1:0] apply_gain(
    input logic signed [SAMPLE_W-1:0] s,
    input logic [7:0]                 g
  );
    logic signed [8:0]          g_q;
    logic signed [SAMPLE_W+8:0] prod;
    g_q  = (g > 8'd128) ? 9'sd128 : $signed({1'b0, g});
    prod = s * g_q;
    return SAMPLE_W'(prod >>> 7);
  endfunction

  logic [7:0]                 gain_arr [CHANNELS];
  logic signed [SAMPLE_W-1:0] sample_p1;
  logic [CHAN_W-1:0]          chan_p1;
  logic                       take_p1;
  logic                       vld_p1;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_gain
    assign gain_arr[k] = gain[k*8 +: 8];
  end

  // Stage p1: table lookup
  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      take_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      take_p1 <= take_p0;
      vld_p1  <= vld_p0;
    end
    if (take_p0) begin
      sample_p1 <= sine_rom[addr_p0];
      chan_p1   <= chan_p0;
    end
  end

  // Stage p2: gain scaling into the output registers
  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      fifo_write_en   <= 1'b0;
      fifo_write_data <= '0;
      fifo_write_chan <= '0;
    end else begin
      fifo_write_en <= vld_p1;
      if (take_p1) begin
        fifo_write_data <= apply_gain(sample_p1, gain_arr[chan_p1]);
        fifo_write_chan <= chan_p1;
      end
    end
  end
`else
  // Stage p1: table lookup into the output registers
  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      fifo_write_en   <= 1'b0;
      fifo_write_data <= '0;
      fifo_write_chan <= '0;
    end else begin
      fifo_write_en <= vld_p0;
      if (take_p0) begin
        fifo_write_data <= sine_rom[addr_p0];
        fifo_write_chan <= chan_p0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_synced_tone_gen.sv
// Directed + randomized bench for spi_synced_tone_gen against a word-level reference model.
`timescale 1ns/1ps
module tb_spi_synced_tone_gen;
  localparam int CH  = 2;
  localparam int SW  = 16;
  localparam int PW  = 16;
  localparam int RAW = 6;
  localparam int BPW = 16;
`ifdef TONE_GAIN_EN
  localparam int LAT         = 6;
  localparam int EXP_PEAK    = 16383;
  localparam int EXP_TROUGH  = -16384;
`else
  localparam int LAT         = 5;
  localparam int EXP_PEAK    = 32767;
  localparam int EXP_TROUGH  = -32767;
`endif

  logic                 clk_12mhz = 1'b0;
  logic                 reset     = 1'b1;
  logic                 spi_sck   = 1'b0;
  logic                 spi_cs    = 1'b1;
  logic                 enable    = 1'b0;
  logic                 fifo_full = 1'b0;
  logic [CH*PW-1:0]     phase_inc = '0;
`ifdef TONE_GAIN_EN
  logic [CH*8-1:0]      gain      = '0;
`endif
  logic signed [SW-1:0] fifo_write_data;
  logic                 fifo_write_en;
  logic [0:0]           fifo_write_chan;
  logic [15:0]          drop_count;
  logic                 led;

  spi_synced_tone_gen #(
    .CHANNELS(CH), .SAMPLE_W(SW), .PHASE_W(PW), .ROM_ADDR_W(RAW), .BITS_PER_WORD(BPW)
  ) dut (
    .clk_12mhz      (clk_12mhz),
    .reset          (reset),
    .spi_sck        (spi_sck),
    .spi_cs         (spi_cs),
    .enable         (enable),
    .phase_inc      (phase_inc),
`ifdef TONE_GAIN_EN
    .gain           (gain),
`endif
    .fifo_full      (fifo_full),
    .fifo_write_data(fifo_write_data),
    .fifo_write_en  (fifo_write_en),
    .fifo_write_chan(fifo_write_chan),
    .drop_count     (drop_count),
    .led            (led)
  );

  always #41 clk_12mhz = ~clk_12mhz;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rise = 0;
  int obs_chan[$];
  int obs_data[$];
  int obs_cyc[$];

  int m_phase[CH];
  int m_chan;
  int m_drop;

  always @(posedge clk_12mhz) cyc <= cyc + 1;

  always @(negedge clk_12mhz) begin
    if (fifo_write_en === 1'b1) begin
      obs_chan.push_back(int'(fifo_write_chan));
      obs_data.push_back(int'(fifo_write_data));
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  function automatic int sine_ref(input int k);
    real amp;
    real x;
    amp = real'((1 << (SW - 1)) - 1);
    x   = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(1 << RAW));
    return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
  endfunction

  function automatic int scaled(input int c, input int s);
`ifdef TONE_GAIN_EN
    int g;
    g = int'(gain[c*8 +: 8]);
    if (g > 128) g = 128;
    return (s * g) >>> 7;
`else
    return s + 0 * c;
`endif
  endfunction

  function automatic int led_ref();
    return ((m_phase[0] >> (PW - RAW)) < ((1 << RAW) / 4)) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs_chan.delete();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk_12mhz);
    #1 reset = 1'b0;
    for (int i = 0; i < CH; i++) m_phase[i] = 0;
    m_chan = 0;
    m_drop = 0;
    clear_obs();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_12mhz);
      #1 spi_sck = 1'b1;
      last_rise = cyc;
      repeat (2) @(posedge clk_12mhz);
      #1 spi_sck = 1'b0;
      @(posedge clk_12mhz);
    end
  endtask

  task automatic cs_abort(input int n);
    pulses(n);
    @(posedge clk_12mhz);
    #1 spi_cs = 1'b1;
    repeat (6) @(posedge clk_12mhz);
    #1 spi_cs = 1'b0;
    repeat (6) @(posedge clk_12mhz);
    #1;
    m_chan = 0;
    check("abort_nowrite", obs_chan.size(), 0);
    clear_obs();
  endtask

  task automatic send_word(input bit en, input bit full, output int got_n, output int got_chan,
                           output int got_data);
    int c, exp_n, exp_chan, exp_data, exp_cyc;
    enable    = en;
    fifo_full = full;
    pulses(BPW);
    repeat (LAT + 4) @(posedge clk_12mhz);
    #1;
    enable    = 1'b1;
    fifo_full = 1'b0;
    exp_n = 0; exp_chan = 0; exp_data = 0; exp_cyc = 0;
    if (en) begin
      c = m_chan;
      if (!full) begin
        exp_n    = 1;
        exp_chan = c;
        exp_data = scaled(c, sine_ref(m_phase[c] >> (PW - RAW)));
        exp_cyc  = last_rise + LAT;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
      m_phase[c] = (m_phase[c] + int'(phase_inc[c*PW +: PW])) % 65536;
      m_chan     = (c + 1) % CH;
    end
    got_n = obs_chan.size();
    got_chan = -1;
    got_data = 0;
    check("write_count", got_n, exp_n);
    if (got_n > 0 && exp_n > 0) begin
      got_chan = obs_chan[0];
      got_data = obs_data[0];
      check("write_chan", obs_chan[0], exp_chan);
      check("write_data", obs_data[0], exp_data);
      check("write_cycle", obs_cyc[0], exp_cyc);
    end
    clear_obs();
    check("drop_count", drop_count, m_drop);
    check("led", led, led_ref());
  endtask

  initial begin
    int n, ch, d;
    int d_ch0[$];
    int r;

    // Reset state
    do_reset();
    check("rst_wen", fifo_write_en, 0);
    check("rst_data", fifo_write_data, 0);
    check("rst_chan", fifo_write_chan, 0);
    check("rst_drop", drop_count, 0);
    check("rst_led", led, 1);

    spi_cs = 1'b0;
    enable = 1'b1;
    phase_inc = {16'h0800, 16'h4000};
`ifdef TONE_GAIN_EN
    gain = {8'd200, 8'd64};
`endif
    repeat (6) @(posedge clk_12mhz);
    #1;

    // Four words alternate channels; channel 0 walks 0 then the positive peak
    for (int w = 0; w < 4; w++) begin
      send_word(1'b1, 1'b0, n, ch, d);
      check("alt_chan", ch, w % 2);
      if (w % 2 == 0) d_ch0.push_back(d);
    end
    check("ch0_first", d_ch0[0], 0);
    check("ch0_second", d_ch0[1], EXP_PEAK);

    // CS abort mid-word realigns the channel index
    send_word(1'b1, 1'b0, n, ch, d);
    cs_abort(10);
    send_word(1'b1, 1'b0, n, ch, d);
    check("cs_realign_n", n, 1);
    check("cs_realign_chan", ch, 0);

    // Disabled triggers leave everything untouched even with the FIFO full
    send_word(1'b0, 1'b1, n, ch, d);
    check("en_low_n", n, 0);
    check("en_low_drop", drop_count, 0);

    // Dropped sample still advances the phase
    do_reset();
    phase_inc = {16'h0800, 16'h4000};
    for (int w = 0; w < 7; w++) begin
      send_word(1'b1, w == 2, n, ch, d);
      if (w == 2) begin
        check("drop_n", n, 0);
        check("drop_cnt1", drop_count, 1);
      end
      if (w == 4) check("after_drop_data", d, 0);
      if (w == 6) check("trough_data", d, EXP_TROUGH);
    end

    // Reset during the trigger cycle cancels the pending write
    pulses(BPW);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk_12mhz);
    #1 reset = 1'b0;
    for (int i = 0; i < CH; i++) m_phase[i] = 0;
    m_chan = 0;
    m_drop = 0;
    repeat (LAT + 4) @(posedge clk_12mhz);
    #1;
    check("midrst_nowrite", obs_chan.size(), 0);
    check("midrst_drop", drop_count, 0);
    check("midrst_data", fifo_write_data, 0);
    check("midrst_chan", fifo_write_chan, 0);
    check("midrst_led", led, 1);
    clear_obs();

    // Randomized traffic
    for (int i = 0; i < CH; i++) phase_inc[i*PW +: PW] = PW'($urandom);
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        cs_abort($urandom_range(1, BPW - 1));
      end else if (r == 1) begin
        for (int i = 0; i < CH; i++) phase_inc[i*PW +: PW] = PW'($urandom);
`ifdef TONE_GAIN_EN
        for (int i = 0; i < CH; i++) gain[i*8 +: 8] = 8'($urandom_range(0, 255));
`endif
      end else begin
        send_word($urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0, n, ch, d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
